// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : Memory-mapped UART with TX/RX FIFOs, status register and IRQs
// Revision : 1.0
// ============================================================================

module uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle
    always_comb begin
        do_pop  = pop & (cnt_q != '0);
        do_push = push & ((cnt_q != FULL_CNT) | do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
endmodule

module uart_fifo #(
    parameter int CLK_DIV    = 326,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        RX_IRQ,
    output logic        TX_IRQ
);
    localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON  = 32'h4000_0020;
    localparam int          DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic        ODD       = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          w_wr_txd, w_wr_con, w_rd_rxd;
    logic [7:0]    tx_head, rx_head;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_pop, rx_push, rx_ferr, rx_ovf;

    logic [2:0] tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_bcnt_q, tx_bcnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_par_q, tx_par_d;
    logic       tx_q, tx_d;
    logic       w_tx_end;

    logic       rx_meta_q, rx_s_q;
    logic [2:0] rx_state_q, rx_state_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bcnt_q, rx_bcnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_perr_q, rx_perr_d;
    logic       w_rx_mid;

    logic [1:0] en_q, en_d;
    logic       ovf_q, ovf_d;
    logic       ferr_q, ferr_d;
    logic [7:0] txd_q, txd_d;
    logic [7:0] w_con;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[31:8];
    assign w_wr_txd     = wr && (addr == ADDR_TXD);
    assign w_wr_con     = wr && (addr == ADDR_CON);
    assign w_rd_rxd     = rd && (addr == ADDR_RXD);

    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (w_wr_txd),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (rx_push),
        .din   (rx_data_q),
        .pop   (w_rd_rxd),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // ---------------- TX FSM ----------------
    assign w_tx_end = tick && (tx_tcnt_q == 4'd15);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        if (tick && (tx_state_q != S_IDLE)) tx_tcnt_d = tx_tcnt_q + 4'd1;
        case (tx_state_q)
            S_IDLE: if (tick && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_d = S_START;
                tx_tcnt_d  = '0;
                tx_shift_d = tx_head & DATA_MASK;
                tx_par_d   = (^(tx_head & DATA_MASK)) ^ ODD;
            end
            S_START: if (w_tx_end) begin
                tx_state_d = S_DATA;
                tx_bcnt_d  = '0;
            end
            S_DATA: if (w_tx_end) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_bcnt_q == LAST_BIT) begin
                    tx_bcnt_d  = '0;
                    tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    tx_bcnt_d = tx_bcnt_q + 3'd1;
                end
            end
            S_PAR: if (w_tx_end) begin
                tx_state_d = S_STOP;
                tx_bcnt_d  = '0;
            end
            S_STOP: if (w_tx_end) begin
                if (tx_bcnt_q == LAST_STOP) tx_state_d = S_IDLE;
                else                        tx_bcnt_d  = tx_bcnt_q + 3'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Line level is registered from the next state so UART_TX never glitches
    always_comb begin
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[0];
            S_PAR:   tx_d = tx_par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign UART_TX = tx_q;

    // ---------------- RX FSM ----------------
    assign w_rx_mid = tick && (rx_tcnt_q == 4'd15);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= UART_RX;
            rx_s_q     <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
        case (rx_state_q)
            S_IDLE: begin
                rx_tcnt_d = '0;
                if (!rx_s_q) rx_state_d = S_START;
            end
            S_START: if (tick && (rx_tcnt_q == 4'd7)) begin
                rx_tcnt_d  = '0;
                rx_bcnt_d  = '0;
                rx_data_d  = '0;
                rx_perr_d  = 1'b0;
                rx_state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_mid) begin
                rx_data_d[rx_bcnt_q] = rx_s_q;
                if (rx_bcnt_q == LAST_BIT) rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
                else                       rx_bcnt_d  = rx_bcnt_q + 3'd1;
            end
            S_PAR: if (w_rx_mid) begin
                rx_perr_d  = rx_s_q ^ (^rx_data_q) ^ ODD;
                rx_state_d = S_STOP;
            end
            S_STOP: if (w_rx_mid) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle makes room, so a full RX FIFO only overflows without a read
    always_comb begin
        rx_push = (rx_state_q == S_STOP) && w_rx_mid && rx_s_q && !rx_perr_q;
        rx_ferr = (rx_state_q == S_STOP) && w_rx_mid && (!rx_s_q || rx_perr_q);
        rx_ovf  = rx_push && rx_full && !w_rd_rxd;
    end

    // ---------------- Registers ----------------
    always_comb begin
        en_d   = en_q;
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        txd_d  = txd_q;
        if (w_wr_txd) txd_d = wdata[7:0];
        if (w_wr_con) begin
            en_d = wdata[1:0];
            if (wdata[5]) ovf_d  = 1'b0;
            if (wdata[6]) ferr_d = 1'b0;
        end
        if (rx_ovf)  ovf_d  = 1'b1;
        if (rx_ferr) ferr_d = 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            en_q   <= 2'b11;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
            txd_q  <= '0;
        end else begin
            div_q  <= div_d;
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
            txd_q  <= txd_d;
        end
    end

    assign w_con = {tx_full, ferr_q, ovf_q, (tx_state_q != S_IDLE), !rx_empty, tx_empty, en_q};

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_TXD: rdata = {24'd0, txd_q};
                ADDR_RXD: rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
                ADDR_CON: rdata = {24'd0, w_con};
                default:  rdata = '0;
            endcase
        end
    end

    assign RX_IRQ = w_con[1] & w_con[3];
    assign TX_IRQ = w_con[0] & w_con[2] & ~w_con[4];
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo
// Brief    : Directed/randomized bench for uart_fifo with queue-based frame model
// Revision : 1.0
// ============================================================================

module tb_uart_fifo;
    localparam int          DIV   = 4;
    localparam int          BIT   = 16 * DIV;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, rd_p, wr_p;
    logic [31:0] addr, wdata, rdata, addr_p, wdata_p, rdata_p;
    logic        rx_line, rx_line_p;
    logic        tx, tx_p, rx_irq, tx_irq, rx_irq_p, tx_irq_p;

    int          errors = 0;
    int          checks = 0;
    logic [9:0]  tx_seen [$];
    logic [7:0]  model [$];

    always #5 clk = ~clk;

    uart_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
        .sysclk(clk), .reset(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .UART_RX(rx_line), .UART_TX(tx), .RX_IRQ(rx_irq), .TX_IRQ(tx_irq)
    );

    uart_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_p (
        .sysclk(clk), .reset(rst_n), .rd(rd_p), .wr(wr_p), .addr(addr_p), .wdata(wdata_p),
        .rdata(rdata_p), .UART_RX(rx_line_p), .UART_TX(tx_p), .RX_IRQ(rx_irq_p), .TX_IRQ(tx_irq_p)
    );

    // Serial decoder: samples each bit at its mid-point, stores {stop, data, start}
    initial begin
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT/2) @(negedge clk);
                f[0] = tx;
                for (int i = 1; i <= 9; i++) begin
                    repeat (BIT) @(negedge clk);
                    f[i] = tx;
                end
                tx_seen.push_back(f);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input bit p, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (p) begin addr_p = a; wdata_p = d; wr_p = 1'b1; end
        else   begin addr   = a; wdata   = d; wr   = 1'b1; end
        @(negedge clk);
        wr = 1'b0; wr_p = 1'b0;
    endtask

    task automatic bus_rd(input bit p, input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        if (p) begin addr_p = a; rd_p = 1'b1; end
        else   begin addr   = a; rd   = 1'b1; end
        #1;
        d = p ? rdata_p : rdata;
        @(negedge clk);
        rd = 1'b0; rd_p = 1'b0;
    endtask

    task automatic drive_rx(input bit p, input logic v);
        if (p) rx_line_p = v; else rx_line = v;
    endtask

    // par_mode: 0 none, 1 correct even parity, 2 inverted parity
    task automatic send_rx(input bit p, input logic [7:0] b, input int par_mode, input bit bad_stop);
        drive_rx(p, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_rx(p, b[i]);
            repeat (BIT) @(negedge clk);
        end
        if (par_mode != 0) begin
            drive_rx(p, (^b) ^ (par_mode == 2));
            repeat (BIT) @(negedge clk);
        end
        if (bad_stop) begin
            drive_rx(p, 1'b0);
            repeat (44) @(negedge clk);
        end
        drive_rx(p, 1'b1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while ((tx_seen.size() < n) && (c < budget)) begin
            @(negedge clk);
            c++;
        end
        check("tx_frame_count", tx_seen.size(), n);
    endtask

    task automatic wait_busy(input logic exp);
        logic [31:0] v;
        int c = 0;
        do begin
            bus_rd(0, A_CON, v);
            c++;
        end while ((v[4] !== exp) && (c < 40));
        check("wait_busy", {31'd0, v[4]}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b, a5;
        logic [7:0]  bytes [17];
        int          n;
        bit          ovf_exp;

        rst_n = 1'b0; rd = 0; wr = 0; rd_p = 0; wr_p = 0;
        addr = '0; wdata = '0; addr_p = '0; wdata_p = '0;
        rx_line = 1'b1; rx_line_p = 1'b1;
        repeat (5) @(negedge clk);
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;

        // Reset state
        bus_rd(0, A_CON, v);  check("con_reset", v, 32'h07);
        check("tx_irq_reset", {31'd0, tx_irq}, 32'd1);
        check("rx_irq_reset", {31'd0, rx_irq}, 32'd0);
        bus_rd(0, A_TXD, v);  check("txd_reset", v, 32'h0);
        bus_rd(0, A_RXD, v);  check("rxd_reset", v, 32'h0);

        // Single frame 0xA5 with bit-level timing
        a5 = 8'hA5;
        bus_wr(0, A_TXD, {24'd0, a5});
        addr = A_CON; rd = 1'b1;
        n = 0;
        while ((tx !== 1'b0) && (n < 50)) begin @(negedge clk); n++; end
        check("a5_start_seen", {31'd0, tx}, 32'd0);
        n = 0;
        while ((tx === 1'b0) && (n < 200)) begin @(negedge clk); n++; end
        check("a5_start_len", n, BIT);
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("a5_data_bit", {31'd0, tx}, {31'd0, a5[i]});
            check("a5_busy", {31'd0, rdata[4]}, 32'd1);
            repeat (BIT) @(negedge clk);
        end
        check("a5_stop_bit", {31'd0, tx}, 32'd1);
        check("a5_stop_busy", {31'd0, rdata[4]}, 32'd1);
        check("a5_irq_in_stop", {31'd0, tx_irq}, 32'd0);
        repeat (BIT/2 + 8) @(negedge clk);
        check("a5_irq_after", {31'd0, tx_irq}, 32'd1);
        check("a5_idle", {31'd0, rdata[4]}, 32'd0);
        rd = 1'b0;
        wait_frames(1, 100);
        if (tx_seen.size() > 0) check("a5_frame", {22'd0, tx_seen.pop_front()}, {22'd0, 1'b1, a5, 1'b0});
        tx_seen.delete();
        bus_rd(0, A_TXD, v);  check("txd_readback", v, {24'd0, a5});

        // Fill TX FIFO while the first frame is on the line
        for (int i = 0; i < 17; i++) bytes[i] = 8'($urandom);
        b = 8'($urandom);
        model.delete();
        model.push_back(b);
        bus_wr(0, A_TXD, {24'd0, b});
        wait_busy(1'b1);
        @(negedge clk);
        wr = 1'b1; addr = A_TXD;
        for (int i = 0; i < 15; i++) begin
            wdata = {24'd0, bytes[i]};
            if (model.size() < 17) model.push_back(bytes[i]);
            @(negedge clk);
        end
        wr = 1'b0;
        bus_rd(0, A_CON, v);  check("tx_full_after15", {31'd0, v[7]}, 32'd0);
        bus_wr(0, A_TXD, {24'd0, bytes[15]});
        if (model.size() < 17) model.push_back(bytes[15]);
        bus_rd(0, A_CON, v);  check("tx_full_after16", {31'd0, v[7]}, 32'd1);
        bus_wr(0, A_TXD, {24'd0, bytes[16]});
        if (model.size() < 17) model.push_back(bytes[16]);
        bus_rd(0, A_CON, v);  check("tx_full_after17", {31'd0, v[7]}, 32'd1);
        wait_frames(17, 13000);
        while (model.size() > 0 && tx_seen.size() > 0)
            check("tx_burst_frame", {22'd0, tx_seen.pop_front()}, {22'd0, 1'b1, model.pop_front(), 1'b0});
        repeat (2 * BIT) @(negedge clk);
        check("tx_no_extra_frame", tx_seen.size(), 0);
        tx_seen.delete();

        // Receive 0x3C
        send_rx(0, 8'h3C, 0, 0);
        bus_rd(0, A_CON, v);  check("rx_nonempty", {31'd0, v[3]}, 32'd1);
        check("rx_irq_set", {31'd0, rx_irq}, 32'd1);
        bus_rd(0, A_RXD, v);  check("rxd_3c", v, 32'h3C);
        bus_rd(0, A_RXD, v);  check("rxd_empty", v, 32'h0);
        bus_rd(0, A_CON, v);  check("rx_empty_flag", {31'd0, v[3]}, 32'd0);
        check("rx_irq_clr", {31'd0, rx_irq}, 32'd0);

        // 17 frames without reads: capacity 16, the rest overflows
        model.delete();
        ovf_exp = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (model.size() < 16) model.push_back(b);
            else ovf_exp = 1'b1;
            send_rx(0, b, 0, 0);
        end
        bus_rd(0, A_CON, v);  check("rx_overflow", {31'd0, v[5]}, {31'd0, ovf_exp});
        while (model.size() > 0) begin
            bus_rd(0, A_RXD, v);
            check("rx_fifo_data", v, {24'd0, model.pop_front()});
        end
        bus_rd(0, A_RXD, v);  check("rx_drained", v, 32'h0);
        bus_wr(0, A_CON, 32'h23);
        bus_rd(0, A_CON, v);  check("ovf_cleared", v, 32'h07);

        // Parity instance: good frame, then wrong parity
        b = 8'($urandom);
        send_rx(1, b, 1, 0);
        bus_rd(1, A_RXD, v);  check("par_good", v, {24'd0, b});
        send_rx(1, 8'($urandom), 2, 0);
        bus_rd(1, A_CON, v);  check("par_error", v, 32'h47);
        bus_wr(1, A_CON, 32'h43);
        bus_rd(1, A_CON, v);  check("par_err_clr", v, 32'h07);

        // Low stop bit, then a short glitch
        send_rx(0, 8'($urandom), 0, 1);
        bus_rd(0, A_CON, v);  check("stop_error", v, 32'h47);
        bus_wr(0, A_CON, 32'h43);
        rx_line = 1'b0;
        repeat (20) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        bus_rd(0, A_CON, v);  check("glitch_ignored", v, 32'h07);

        // Reset mid-frame with both FIFOs populated
        send_rx(0, 8'($urandom), 0, 0);
        bus_wr(0, A_TXD, 32'h00);
        wait_busy(1'b1);
        bus_wr(0, A_TXD, 32'h5A);
        repeat (100) @(negedge clk);
        check("tx_low_midframe", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("tx_async_reset", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(0, A_CON, v);  check("con_after_reset", v, 32'h07);
        bus_rd(0, A_RXD, v);  check("rxd_after_reset", v, 32'h0);
        bus_rd(0, A_TXD, v);  check("txd_after_reset", v, 32'h0);
        repeat (12 * BIT) @(negedge clk);
        tx_seen.delete();
        repeat (12 * BIT) @(negedge clk);
        check("no_tx_after_reset", tx_seen.size(), 0);
        b = 8'($urandom);
        bus_wr(0, A_TXD, {24'd0, b});
        wait_frames(1, 800);
        if (tx_seen.size() > 0) check("first_frame_after_reset", {22'd0, tx_seen.pop_front()}, {22'd0, 1'b1, b, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 326, sysclk cycles per 16x-oversample tick (326 = 9600 baud at 50 MHz).
REQ-002 SHALL have parameter DATA_BITS, default 8, frame data width, legal 5..8.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO, power of 2, minimum 2.
REQ-006 SHALL have port sysclk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have ports rd and wr, input, 1 each, bus read and write strobes.
REQ-009 SHALL have ports addr and wdata, input, 32 each, and rdata, output, 32, bus address and data.
REQ-010 SHALL have port UART_RX, input, 1, serial input, asynchronous to sysclk.
REQ-011 SHALL have port UART_TX, output, 1, serial output.
REQ-012 SHALL have ports RX_IRQ and TX_IRQ, output, 1 each, level interrupts.

Function
REQ-013 SHALL use this register map: 0x40000018 TXD (write pushes TX FIFO; read returns last written byte); 0x4000001C RXD (read returns RX FIFO head and pops it); 0x40000020 CON.
REQ-014 SHALL define CON bits as follows: [0] TX IRQ enable (RW); [1] RX IRQ enable (RW); [2] TX FIFO empty (RO); [3] RX FIFO non-empty (RO); [4] TX busy (RO); [5] RX overflow, sticky, write-1-clear; [6] RX framing/parity error, sticky, write-1-clear; [7] TX FIFO full (RO); [31:8] read 0.
REQ-015 SHALL drive rdata combinationally: rd=1 with a mapped addr gives the value, zero-extended; otherwise 0.
REQ-016 SHALL pop the RX FIFO exactly once per sysclk cycle in which rd=1 and addr=RXD; reading RXD when the RX FIFO is empty SHALL return 0 and SHALL NOT pop.
REQ-017 SHALL drop wdata silently when TXD is written while the TX FIFO is full, leaving FIFO contents unchanged.
REQ-018 SHALL apply both a push and a pop issued in the same cycle, leaving the FIFO count unchanged; a push to a full FIFO that coincides with a pop SHALL be accepted.
REQ-019 SHALL generate a 1-cycle oversample tick every CLK_DIV sysclk cycles from a free-running counter; one bit time SHALL be 16 ticks.
REQ-020 SHALL run a TX FSM with states IDLE -> START -> DATA(DATA_BITS, LSB first) -> PARITY (only if PARITY!=0) -> STOP(STOP_BITS) -> IDLE.
REQ-021 SHALL, on a tick in IDLE with the TX FIFO non-empty, pop the FIFO into a shift register and enter START; UART_TX SHALL be 0 in START, data bits in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-022 SHALL hold CON[4]=1 in every TX state except IDLE.
REQ-023 SHALL pass UART_RX through a 2-flop synchronizer before any use.
REQ-024 SHALL run an RX FSM with states IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE; IDLE SHALL enter START on a synchronized low level.
REQ-025 SHALL re-sample in START after 8 ticks; a high sample SHALL be treated as a false start and return the FSM to IDLE with nothing pushed.
REQ-026 SHALL sample each subsequent bit at 16-tick intervals from the start-bit mid-point, checking only the first stop bit.
REQ-027 SHALL, on a low stop bit or a parity mismatch, discard the byte and set CON[6].
REQ-028 SHALL otherwise push the byte, zero-extended to 8 bits, into the RX FIFO; if the RX FIFO is full, it SHALL drop the byte and set CON[5].
REQ-029 SHALL drive RX_IRQ = CON[1] & CON[3] and TX_IRQ = CON[0] & CON[2] & ~CON[4].

Reset
REQ-030 SHALL, while reset=0, asynchronously clear both FIFOs, all counters, TXD and CON[5] and CON[6], set CON[1:0]=2'b11, return both FSMs to IDLE, and force UART_TX=1.
REQ-031 SHALL abort any in-flight frame on reset assertion mid-frame, with UART_TX going to 1 without waiting for a clock; the first frame after release SHALL start only from a newly written TXD.

Verification (CLK_DIV=4, so one bit time = 64 sysclk cycles)
REQ-032 SHALL cover: write TXD=0xA5 -> UART_TX shows 0, bits 1,0,1,0,0,1,0,1, then 1, each bit 64 cycles; CON[4]=1 throughout; TX_IRQ rises after the stop bit.
REQ-033 SHALL cover: write 17 bytes back-to-back with FIFO_DEPTH=16 -> CON[7]=1 after the 16th write, the 17th byte is dropped, 16 frames are sent in order.
REQ-034 SHALL cover: drive frame 0x3C on UART_RX -> CON[3]=1 and RX_IRQ=1; read RXD returns 0x3C; next read returns 0 and CON[3]=0.
REQ-035 SHALL cover: 17 received frames with no reads -> CON[5]=1 and 16 bytes readable; writing CON with bit5=1 clears CON[5].
REQ-036 SHALL cover: PARITY=1 with a wrong parity bit, or a low stop bit -> CON[6]=1 and nothing pushed; a 20-cycle low glitch -> nothing pushed and no error.
REQ-037 SHALL cover: reset pulsed mid-TX-frame -> UART_TX=1 immediately, CON reads 0x07, both FIFOs empty.
